robot_motion_sequencer: RTL and testbench
=========================================

// Module: robot_motion_sequencer
// PURPOSE
//  Sequences the wall-following navigation FSM's front/turn commands into timed motor actions.
//  Sits between that FSM and the two drive motors: accepts one command per handshake,
//  drives the motors for a fixed duration, and lets them settle.
//  Then pulses sensor_sample so the FSM latches fresh sensors and issues the next command.
//  Also flags spinning in place (too many consecutive turns).
// PARAMETERS
//  FWD_CYCLES     16  cycles both motors run forward per front command (>=1)
//  TURN_CYCLES    24  cycles of in-place right turn per turn command (>=1)
//  SETTLE_CYCLES  4   cycles motors stopped before sensors are sampled (>=1)
//  SPIN_LIMIT     4   consecutive accepted turns that raise spin_alarm (>=1)
// PORTS
//  clk           in   1  system clock, all logic on posedge
//  rst_n         in   1  synchronous reset, active-low
//  cmd_valid     in   1  navigation FSM presents a command
//  cmd_front     in   1  command: drive forward
//  cmd_turn      in   1  command: turn right in place
//  cmd_ready     out  1  sequencer can accept a command this cycle
//  halt          in   1  emergency stop, level-sensitive
//  motor_l       out  2  left motor: 00 stop, 01 fwd, 10 rev (11 never driven)
//  motor_r       out  2  right motor, same encoding
//  sensor_sample out  1  1-cycle strobe: action finished, sample sensors / advance FSM
//  busy          out  1  1 whenever state != IDLE
//  spin_alarm    out  1  consecutive-turn limit reached
// BEHAVIOUR
//  Output type and reset:
//  - All outputs are registered.
//  - rst_n=0 at posedge: state=IDLE, motors 00, cmd_ready=1, sensor_sample=0, busy=0,
//    spin_alarm=0, counters 0.
//  - Reset mid-action aborts immediately; no sample strobe is generated.
//  States: IDLE, FWD, TURN, SETTLE, HALTED.
//  IDLE:
//  - cmd_ready=1 only in IDLE and only when halt=0.
//  - A command is accepted on a posedge with cmd_valid&cmd_ready.
//  - Accept with turn=1 -> TURN; front overrides nothing, so {1,1} counts as a turn.
//  - Accept with {front,turn}={1,0} -> FWD.
//  - Accept with {0,0} -> SETTLE directly; no motion, a sample is still produced.
//  FWD:
//  - motor_l=motor_r=01 for exactly FWD_CYCLES cycles, starting the cycle after accept.
//  - Then -> SETTLE.
//  TURN:
//  - motor_l=01, motor_r=10 for exactly TURN_CYCLES cycles.
//  - Then -> SETTLE.
//  SETTLE:
//  - Motors 00 for SETTLE_CYCLES cycles, then -> IDLE.
//  - The IDLE entry cycle has sensor_sample=1 and cmd_ready=1 together.
//  - Minimum accept-to-accept spacing: FWD = FWD_CYCLES+SETTLE_CYCLES+1;
//    TURN = TURN_CYCLES+SETTLE_CYCLES+1.
//  Duration counter:
//  - One shared down-counter, width $clog2(max(FWD,TURN,SETTLE)+1).
//  - Loaded with N-1 on state entry; the state exits when it reads 0.
//  - No wrap: it is reloaded before reuse.
//  halt:
//  - halt=1 in any state -> HALTED at the next posedge; motors 00 from that cycle.
//  - Any in-flight action is discarded.
//  - HALTED holds while halt=1; on halt=0 -> SETTLE, then sample as normal.
//  - halt=1 in IDLE with cmd_valid=1: the command is NOT accepted (cmd_ready=0).
//  Spin counter:
//  - Saturating, width $clog2(SPIN_LIMIT+1).
//  - Increments on each accepted turn; clears on each accepted front-only command.
//  - {0,0} commands and halt leave it unchanged.
//  - spin_alarm=1 while count==SPIN_LIMIT; it asserts the cycle after the
//    SPIN_LIMIT-th turn is accepted.
//  - It clears the cycle after a forward is accepted, or on reset.
// STRUCTURE
//  - Shared package robot_pkg: motor encodings (MOTOR_STOP/FWD/REV) and the sequencer
//    state localparams, reused by the navigation FSM and the motor driver.
//  - One natural sub-module: robot_duration_timer (load value, load, tick, done).
//  - Everything else stays flat.
// TESTING
//  - Reset: rst_n=0 for 2 cycles -> all outputs at reset values; cmd_ready=1.
//  - Forward (default params): accept {1,0} at cycle 0 -> motors 01/01 cycles 1-16,
//    00 cycles 17-20, sensor_sample=1 and cmd_ready=1 at cycle 21.
//  - Turn: accept {1,1} -> motor_l=01, motor_r=10 for 24 cycles, 4 settle cycles,
//    then a single sample pulse; no accept is possible while busy.
//  - Spin: 4 back-to-back turns -> spin_alarm=1 the cycle after the 4th accept;
//    a 5th turn keeps it at 1; a forward accept clears it next cycle.
//  - Halt: halt=1 at cycle 5 of FWD -> motors 00 next cycle; released after 10 cycles
//    -> 4 settle cycles, then sensor_sample; cmd_valid held during halt is not accepted.
//  - No-op and reset abort: {0,0} accept -> SETTLE, sample after 5 cycles, no motor
//    activity; rst_n=0 mid-TURN -> next cycle motors 00, no sample pulse.

Source files
------------

// File: rtl/robot_pkg.sv
// Shared definitions for the robot drive path: motor command encodings and
// the motion sequencer state set, used by the navigation FSM, the motor
// driver and the sequencer itself.
package robot_pkg;

  // Per-motor drive command; 2'b11 is never driven.
  localparam logic [1:0] MOTOR_STOP = 2'b00;
  localparam logic [1:0] MOTOR_FWD  = 2'b01;
  localparam logic [1:0] MOTOR_REV  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FWD    = 3'd1,
    ST_TURN   = 3'd2,
    ST_SETTLE = 3'd3,
    ST_HALTED = 3'd4
  } seq_state_t;

  // Largest of three durations; sizes the shared duration counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/robot_duration_timer.sv
// Shared down-counter timing each motion/settle phase. Loaded with N-1 on
// phase entry; done reads high once the count has reached zero, where it
// stays until the next load.
module robot_duration_timer #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             tick,
  output logic             done
);

  logic [WIDTH-1:0] count;

  // Load wins over tick; counting stops at zero so the counter never wraps.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (tick && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/robot_motion_sequencer.sv
// Turns front/turn commands from the wall-following FSM into timed motor
// actions, lets the motors settle, then strobes sensor_sample so the FSM
// can latch fresh sensors. Also tracks consecutive turns to flag spinning.
module robot_motion_sequencer
  import robot_pkg::*;
#(
  parameter int FWD_CYCLES    = 16,
  parameter int TURN_CYCLES   = 24,
  parameter int SETTLE_CYCLES = 4,
  parameter int SPIN_LIMIT    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  input  logic       cmd_front,
  input  logic       cmd_turn,
  output logic       cmd_ready,
  input  logic       halt,
  output logic [1:0] motor_l,
  output logic [1:0] motor_r,
  output logic       sensor_sample,
  output logic       busy,
  output logic       spin_alarm
);

  localparam int CNT_W  = $clog2(max3(FWD_CYCLES, TURN_CYCLES, SETTLE_CYCLES) + 1);
  localparam int SPIN_W = $clog2(SPIN_LIMIT + 1);

  localparam logic [CNT_W-1:0]  FWD_LOAD    = CNT_W'(FWD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  TURN_LOAD   = CNT_W'(TURN_CYCLES - 1);
  localparam logic [CNT_W-1:0]  SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [SPIN_W-1:0] SPIN_MAX    = SPIN_W'(SPIN_LIMIT);

  seq_state_t        state_q, state_d;
  logic [SPIN_W-1:0] spin_q, spin_d;
  logic              accept;
  logic              sample_d;
  logic [1:0]        motor_l_d, motor_r_d;
  logic              tmr_load, tmr_tick, tmr_done;
  logic [CNT_W-1:0]  tmr_value;

  assign tmr_tick = (state_q == ST_FWD) || (state_q == ST_TURN) || (state_q == ST_SETTLE);

  robot_duration_timer #(
    .WIDTH (CNT_W)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (tmr_load),
    .load_value (tmr_value),
    .tick       (tmr_tick),
    .done       (tmr_done)
  );

  // Next state, timer loads, spin count and next registered outputs.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    state_d   = state_q;
    spin_d    = spin_q;
    sample_d  = 1'b0;
    tmr_load  = 1'b0;
    tmr_value = '0;
    accept    = cmd_valid && cmd_ready && !halt && (state_q == ST_IDLE);

    if (halt) begin
      // Emergency stop discards whatever action is in flight.
      state_d = ST_HALTED;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            tmr_load = 1'b1;
            if (cmd_turn) begin
              // Turn wins when both bits are set.
              state_d   = ST_TURN;
              tmr_value = TURN_LOAD;
              if (spin_q != SPIN_MAX) spin_d = spin_q + SPIN_W'(1);
            end else if (cmd_front) begin
              state_d   = ST_FWD;
              tmr_value = FWD_LOAD;
              spin_d    = '0;
            end else begin
              // No-op command: skip motion but still settle and sample.
              state_d   = ST_SETTLE;
              tmr_value = SETTLE_LOAD;
            end
          end
        end
        ST_FWD, ST_TURN: begin
          if (tmr_done) begin
            state_d   = ST_SETTLE;
            tmr_load  = 1'b1;
            tmr_value = SETTLE_LOAD;
          end
        end
        ST_SETTLE: begin
          if (tmr_done) begin
            state_d  = ST_IDLE;
            sample_d = 1'b1;
          end
        end
        ST_HALTED: begin
          state_d   = ST_SETTLE;
          tmr_load  = 1'b1;
          tmr_value = SETTLE_LOAD;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    case (state_d)
      ST_FWD: begin
        motor_l_d = MOTOR_FWD;
        motor_r_d = MOTOR_FWD;
      end
      ST_TURN: begin
        motor_l_d = MOTOR_FWD;
        motor_r_d = MOTOR_REV;
      end
      default: begin
        motor_l_d = MOTOR_STOP;
        motor_r_d = MOTOR_STOP;
      end
    endcase
  end

  // State, spin count and all outputs registered together; sync reset aborts any action.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      spin_q        <= '0;
      motor_l       <= MOTOR_STOP;
      motor_r       <= MOTOR_STOP;
      sensor_sample <= 1'b0;
      cmd_ready     <= 1'b1;
      busy          <= 1'b0;
      spin_alarm    <= 1'b0;
    end else begin
      state_q       <= state_d;
      spin_q        <= spin_d;
      motor_l       <= motor_l_d;
      motor_r       <= motor_r_d;
      sensor_sample <= sample_d;
      cmd_ready     <= (state_d == ST_IDLE);
      busy          <= (state_d != ST_IDLE);
      spin_alarm    <= (spin_d == SPIN_MAX);
    end
  end

endmodule

// File: tb/tb_robot_motion_sequencer.sv
// Scoreboard bench for robot_motion_sequencer at default parameters.
// Stimulus pushes expected output snapshots (by cycle) and expected
// sensor_sample cycles; a negedge monitor pops and compares them.
module tb_robot_motion_sequencer;
  import robot_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid, cmd_front, cmd_turn, halt;
  logic       cmd_ready, sensor_sample, busy, spin_alarm;
  logic [1:0] motor_l, motor_r;

  int cyc      = 0;
  int checks   = 0;
  int errors   = 0;
  int exp_spin = 0;

  typedef struct {
    int         cyc;
    logic [7:0] vec;   // {motor_l, motor_r, sample, ready, busy, alarm}
    string      name;
  } snap_t;

  snap_t snap_q[$];
  int    sample_q[$];

  robot_motion_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cmd_valid     (cmd_valid),
    .cmd_front     (cmd_front),
    .cmd_turn      (cmd_turn),
    .cmd_ready     (cmd_ready),
    .halt          (halt),
    .motor_l       (motor_l),
    .motor_r       (motor_r),
    .sensor_sample (sensor_sample),
    .busy          (busy),
    .spin_alarm    (spin_alarm)
  );

  always #5 clk = ~clk;

  // cyc = number of posedges so far; outputs seen at negedge belong to cyc.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_at(input int c, input logic [1:0] ml, input logic [1:0] mr,
                           input logic smp, input logic rdy, input logic bsy,
                           input logic alm, input string name);
    snap_t s;
    s.cyc  = c;
    s.vec  = {ml, mr, smp, rdy, bsy, alm};
    s.name = name;
    snap_q.push_back(s);
  endtask

  // Monitor: sample pulses are matched against expected cycles, snapshots by cycle.
  always @(negedge clk) begin
    snap_t s;
    if (sensor_sample === 1'b1) begin
      if (sample_q.size() == 0) check($sformatf("sample_unexpected@%0d", cyc), 1, 0);
      else check($sformatf("sample_cycle@%0d", cyc), cyc, sample_q.pop_front());
    end else if (sample_q.size() != 0 && sample_q[0] <= cyc) begin
      check($sformatf("sample_missing@%0d", sample_q.pop_front()), 0, 1);
    end
    while (snap_q.size() != 0 && snap_q[0].cyc <= cyc) begin
      s = snap_q.pop_front();
      if (s.cyc < cyc) check({s.name, "_missed"}, cyc, s.cyc);
      else check($sformatf("%s@%0d", s.name, cyc),
                 {24'b0, motor_l, motor_r, sensor_sample, cmd_ready, busy, spin_alarm},
                 {24'b0, s.vec});
    end
  end

  // Issue one command from IDLE (at a negedge) and expect its full timeline.
  // cmd_valid stays high through the action so any early accept would show.
  task automatic run_action(input logic front, input logic turn, input logic keep_valid,
                            input string name);
    int a, d;
    logic [1:0] ml, mr;
    logic alm;
    a  = cyc + 1;
    d  = turn ? 24 : (front ? 16 : 0);
    ml = (turn || front) ? MOTOR_FWD : MOTOR_STOP;
    mr = turn ? MOTOR_REV : (front ? MOTOR_FWD : MOTOR_STOP);
    if (turn) exp_spin = (exp_spin < 4) ? exp_spin + 1 : 4;
    else if (front) exp_spin = 0;
    alm = (exp_spin == 4);
    cmd_valid = 1'b1;
    cmd_front = front;
    cmd_turn  = turn;
    if (d > 0) begin
      expect_at(a,         ml, mr, 1'b0, 1'b0, 1'b1, alm, {name, "_move_first"});
      expect_at(a + d - 1, ml, mr, 1'b0, 1'b0, 1'b1, alm, {name, "_move_last"});
    end
    expect_at(a + d,     MOTOR_STOP, MOTOR_STOP, 1'b0, 1'b0, 1'b1, alm, {name, "_settle_first"});
    expect_at(a + d + 3, MOTOR_STOP, MOTOR_STOP, 1'b0, 1'b0, 1'b1, alm, {name, "_settle_last"});
    expect_at(a + d + 4, MOTOR_STOP, MOTOR_STOP, 1'b1, 1'b1, 1'b0, alm, {name, "_sample"});
    if (!keep_valid)
      expect_at(a + d + 5, MOTOR_STOP, MOTOR_STOP, 1'b0, 1'b1, 1'b0, alm, {name, "_idle"});
    sample_q.push_back(a + d + 4);
    repeat (d + 5) @(negedge clk);
    if (!keep_valid) begin
      cmd_valid = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    int a;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_front = 1'b0; cmd_turn = 1'b0; halt = 1'b0;

    // Reset held for two edges.
    expect_at(1, MOTOR_STOP, MOTOR_STOP, 1'b0, 1'b1, 1'b0, 1'b0, "reset_c1");
    expect_at(2, MOTOR_STOP, MOTOR_STOP, 1'b0, 1'b1, 1'b0, 1'b0, "reset_c2");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single turn ({1,1} counts as turn), then forward (clears spin).
    run_action(1'b1, 1'b1, 1'b0, "turn");
    run_action(1'b1, 1'b0, 1'b0, "fwd");

    // Five back-to-back turns, a no-op that keeps the alarm, then a clearing forward.
    run_action(1'b0, 1'b1, 1'b1, "spin1");
    run_action(1'b0, 1'b1, 1'b1, "spin2");
    run_action(1'b0, 1'b1, 1'b1, "spin3");
    run_action(1'b0, 1'b1, 1'b1, "spin4");
    run_action(1'b0, 1'b1, 1'b1, "spin5");
    run_action(1'b0, 1'b0, 1'b0, "noop");
    run_action(1'b1, 1'b0, 1'b0, "fwd_clear");

    // Halt at FWD cycle 5 for 10 cycles, cmd_valid held during halt.
    a = cyc + 1;
    cmd_valid = 1'b1; cmd_front = 1'b1; cmd_turn = 1'b0;
    exp_spin = 0;
    expect_at(a,      MOTOR_FWD,  MOTOR_FWD,  1'b0, 1'b0, 1'b1, 1'b0, "halt_fwd_run");
    expect_at(a + 4,  MOTOR_FWD,  MOTOR_FWD,  1'b0, 1'b0, 1'b1, 1'b0, "halt_fwd_c5");
    expect_at(a + 5,  MOTOR_STOP, MOTOR_STOP, 1'b0, 1'b0, 1'b1, 1'b0, "halt_stop");
    expect_at(a + 14, MOTOR_STOP, MOTOR_STOP, 1'b0, 1'b0, 1'b1, 1'b0, "halt_hold");
    expect_at(a + 15, MOTOR_STOP, MOTOR_STOP, 1'b0, 1'b0, 1'b1, 1'b0, "halt_settle_first");
    expect_at(a + 18, MOTOR_STOP, MOTOR_STOP, 1'b0, 1'b0, 1'b1, 1'b0, "halt_settle_last");
    expect_at(a + 19, MOTOR_STOP, MOTOR_STOP, 1'b1, 1'b1, 1'b0, 1'b0, "halt_sample");
    expect_at(a + 20, MOTOR_STOP, MOTOR_STOP, 1'b0, 1'b1, 1'b0, 1'b0, "halt_idle");
    sample_q.push_back(a + 19);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    halt = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_front = 1'b1;
    repeat (9) @(negedge clk);
    halt = 1'b0; cmd_valid = 1'b0;
    repeat (6) @(negedge clk);

    // Halt in IDLE blocks a pending turn command.
    a = cyc + 1;
    halt = 1'b1; cmd_valid = 1'b1; cmd_front = 1'b0; cmd_turn = 1'b1;
    expect_at(a,     MOTOR_STOP, MOTOR_STOP, 1'b0, 1'b0, 1'b1, 1'b0, "idle_halt_block");
    expect_at(a + 1, MOTOR_STOP, MOTOR_STOP, 1'b0, 1'b0, 1'b1, 1'b0, "idle_halt_settle");
    expect_at(a + 5, MOTOR_STOP, MOTOR_STOP, 1'b1, 1'b1, 1'b0, 1'b0, "idle_halt_sample");
    expect_at(a + 6, MOTOR_STOP, MOTOR_STOP, 1'b0, 1'b1, 1'b0, 1'b0, "idle_halt_idle");
    sample_q.push_back(a + 5);
    @(negedge clk);
    halt = 1'b0; cmd_valid = 1'b0;
    repeat (6) @(negedge clk);

    // Three turns, then the 4th (alarm up) is aborted by reset mid-TURN.
    run_action(1'b0, 1'b1, 1'b1, "pre1");
    run_action(1'b0, 1'b1, 1'b1, "pre2");
    run_action(1'b0, 1'b1, 1'b1, "pre3");
    a = cyc + 1;
    exp_spin = 4;
    expect_at(a,      MOTOR_FWD,  MOTOR_REV,  1'b0, 1'b0, 1'b1, 1'b1, "abort_turn");
    expect_at(a + 6,  MOTOR_STOP, MOTOR_STOP, 1'b0, 1'b1, 1'b0, 1'b0, "abort_reset");
    expect_at(a + 7,  MOTOR_STOP, MOTOR_STOP, 1'b0, 1'b1, 1'b0, 1'b0, "abort_idle");
    expect_at(a + 40, MOTOR_STOP, MOTOR_STOP, 1'b0, 1'b1, 1'b0, 1'b0, "abort_quiet");
    repeat (6) @(negedge clk);
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_turn = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_spin = 0;
    repeat (35) @(negedge clk);

    check("samples_pending", sample_q.size(), 0);
    check("snaps_pending", snap_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
